a25_mem_load: RTL and testbench

Memory-access stage feeding `a25_write_back`. Accepts one load/store per request from execute and runs a req/ack data bus. For loads, it extracts and sign- or zero-extends the byte, halfword or word, then presents it to write-back as `o_mem_read_data` / `o_mem_read_data_valid` / `o_mem_load_rd`. `o_mem_stall` drives `i_mem_stall` of write-back and back-pressures execute.

---
 rtl/a25_mem_pkg.sv | 30 +++
 rtl/a25_mem_align.sv | 68 ++++++
 rtl/a25_mem_load.sv | 151 +++++++++++++++
 tb/tb_a25_mem_load.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a25_mem_pkg.sv
// a25_mem_pkg: shared encodings for the a25 memory-access stage.
// Size codes, FSM state type, write-back tag width and an alignment helper.
package a25_mem_pkg;

   localparam int LOAD_RD_W = 11;

   localparam logic [1:0] MEM_BYTE = 2'b00;
   localparam logic [1:0] MEM_HALF = 2'b01;
   localparam logic [1:0] MEM_WORD = 2'b10;

   typedef enum logic [1:0] {
      MEM_IDLE  = 2'b00,
      MEM_BUSY  = 2'b01,
      MEM_ABORT = 2'b10
   } mem_state_t;

   // True when the low address bits do not match the natural alignment of
   // the access size (size code 11 behaves as a word).
   function automatic logic f_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
      logic mis;
      case (size)
         MEM_BYTE: mis = 1'b0;
         MEM_HALF: mis = addr_lo[0];
         default:  mis = (addr_lo != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/a25_mem_align.sv
// a25_mem_align: combinational byte-lane logic for the memory stage.
// Produces store byte enables, lane-replicated store data and the
// extracted, sign/zero-extended load value for a given size and address.
module a25_mem_align
   import a25_mem_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_addr_lo,
   input  logic        i_signed,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Byte field widened to 32 bits, sign-extended when requested.
   function automatic logic [31:0] f_ext8(input logic [7:0] v, input logic s);
      logic signed [7:0] sv;
      sv = v;
      return s ? 32'(sv) : {24'd0, v};
   endfunction

   // Halfword field widened to 32 bits, sign-extended when requested.
   function automatic logic [31:0] f_ext16(input logic [15:0] v, input logic s);
      logic signed [15:0] sv;
      sv = v;
      return s ? 32'(sv) : {16'd0, v};
   endfunction

   // Lane selection plus byte-enable / replication decode by access size.
   always_comb begin
      w_byte  = 8'd0;
      w_half  = 16'd0;
      o_be    = 4'b1111;
      o_wdata = i_wdata;
      o_rdata = i_rdata;
      case (i_addr_lo)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      // addr[0] is deliberately not used: halfwords only pick by addr[1]
      w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
      case (i_size)
         MEM_BYTE: begin
            o_be    = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_wdata[7:0]}};
            o_rdata = f_ext8(w_byte, i_signed);
         end
         MEM_HALF: begin
            o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
            o_wdata = {2{i_wdata[15:0]}};
            o_rdata = f_ext16(w_half, i_signed);
         end
         default: begin
            o_be    = 4'b1111;
            o_wdata = i_wdata;
            o_rdata = i_rdata;
         end
      endcase
   end

endmodule

// File: rtl/a25_mem_load.sv
// a25_mem_load: memory-access stage between execute and write-back.
// Accepts one load/store, runs a req/ack bus transaction and returns
// aligned load data to write-back with a one-cycle valid pulse.
// Optional build macro A25_MEM_ALIGN_CHECK_EN: misaligned halfword/word
// accesses are aborted (one-cycle o_mem_abort) instead of being issued.
module a25_mem_load
   import a25_mem_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_exec_valid,
   input  logic                 i_exec_write,
   input  logic [1:0]           i_exec_size,
   input  logic                 i_exec_signed,
   input  logic [31:0]          i_exec_addr,
   input  logic [31:0]          i_exec_wdata,
   input  logic [LOAD_RD_W-1:0] i_exec_load_rd,
   output logic                 o_bus_req,
   output logic                 o_bus_we,
   output logic [31:0]          o_bus_addr,
   output logic [3:0]           o_bus_be,
   output logic [31:0]          o_bus_wdata,
   input  logic                 i_bus_ack,
   input  logic [31:0]          i_bus_rdata,
   output logic                 o_mem_stall,
   output logic [31:0]          o_mem_read_data,
   output logic                 o_mem_read_data_valid,
   output logic [LOAD_RD_W-1:0] o_mem_load_rd,
   output logic [31:0]          o_daddress,
   output logic                 o_daddress_valid,
   output logic                 o_mem_abort
);

   mem_state_t           r_state;
   mem_state_t           w_next_state;
   mem_state_t           w_accept_state;
   logic                 w_accept;
   logic                 w_ack_done;

   logic                 r_write_p0;
   logic [1:0]           r_size_p0;
   logic                 r_signed_p0;
   logic [31:0]          r_addr_p0;
   logic [31:0]          r_wdata_p0;
   logic [LOAD_RD_W-1:0] r_load_rd_p0;

   logic [31:0]          r_rd_data_p1;
   logic [LOAD_RD_W-1:0] r_rd_tag_p1;
   logic [31:0]          r_daddr_p1;
   logic                 r_rd_vld_p1;
   logic                 r_da_vld_p1;

   logic [3:0]           w_be;
   logic [31:0]          w_bus_wdata;
   logic [31:0]          w_rd_ext;

   assign w_accept   = (r_state == MEM_IDLE) & i_exec_valid;
   assign w_ack_done = (r_state == MEM_BUSY) & i_bus_ack;

`ifdef A25_MEM_ALIGN_CHECK_EN
   assign w_accept_state = f_misaligned(i_exec_size, i_exec_addr[1:0]) ? MEM_ABORT : MEM_BUSY;
   assign o_mem_abort    = (r_state == MEM_ABORT);
`else
   assign w_accept_state = MEM_BUSY;
   assign o_mem_abort    = 1'b0;
`endif

   a25_mem_align u_align (
      .i_size    (r_size_p0),
      .i_addr_lo (r_addr_p0[1:0]),
      .i_signed  (r_signed_p0),
      .i_wdata   (r_wdata_p0),
      .i_rdata   (i_bus_rdata),
      .o_be      (w_be),
      .o_wdata   (w_bus_wdata),
      .o_rdata   (w_rd_ext)
   );

   // State register; reset forces IDLE and drops any in-flight access.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= MEM_IDLE;
      else          r_state <= w_next_state;
   end

   // Next-state decode and state-derived outputs (stall, bus drive).
   always_comb begin
      w_next_state = r_state;
      o_mem_stall  = (r_state != MEM_IDLE);
      o_bus_req    = 1'b0;
      o_bus_we     = 1'b0;
      o_bus_addr   = 32'd0;
      o_bus_be     = 4'd0;
      o_bus_wdata  = 32'd0;
      case (r_state)
         MEM_IDLE: begin
            if (i_exec_valid) w_next_state = w_accept_state;
         end
         MEM_BUSY: begin
            o_bus_req   = 1'b1;
            o_bus_we    = r_write_p0;
            o_bus_addr  = {r_addr_p0[31:2], 2'b00};
            o_bus_be    = w_be;
            o_bus_wdata = w_bus_wdata;
            if (i_bus_ack) w_next_state = MEM_IDLE;
         end
         default: w_next_state = MEM_IDLE;
      endcase
   end

   // ---- p0: request capture at acceptance ----
   // Request fields held steady for the duration of the bus transaction.
   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_write_p0   <= i_exec_write;
         r_size_p0    <= i_exec_size;
         r_signed_p0  <= i_exec_signed;
         r_addr_p0    <= i_exec_addr;
         r_wdata_p0   <= i_exec_wdata;
         r_load_rd_p0 <= i_exec_load_rd;
      end
   end

   // ---- p1: completion results toward write-back ----
   // Result/address registers hold between completions; valids pulse once.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_rd_data_p1 <= 32'd0;
         r_rd_tag_p1  <= '0;
         r_daddr_p1   <= 32'd0;
         r_rd_vld_p1  <= 1'b0;
         r_da_vld_p1  <= 1'b0;
      end else begin
         r_rd_vld_p1 <= w_ack_done & ~r_write_p0;
         r_da_vld_p1 <= w_ack_done;
         if (w_ack_done) begin
            r_daddr_p1 <= r_addr_p0;
            if (!r_write_p0) begin
               r_rd_data_p1 <= w_rd_ext;
               r_rd_tag_p1  <= r_load_rd_p0;
            end
         end
      end
   end

   assign o_mem_read_data       = r_rd_data_p1;
   assign o_mem_load_rd         = r_rd_tag_p1;
   assign o_mem_read_data_valid = r_rd_vld_p1;
   assign o_daddress            = r_daddr_p1;
   assign o_daddress_valid      = r_da_vld_p1;

endmodule

// File: tb/tb_a25_mem_load.sv
// tb_a25_mem_load: table-driven bench with a completion scoreboard.
module tb_a25_mem_load;
   import a25_mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        exec_valid = 1'b0, exec_write = 1'b0, exec_signed = 1'b0;
   logic [1:0]  exec_size = 2'b00;
   logic [31:0] exec_addr = 32'd0, exec_wdata = 32'd0;
   logic [10:0] exec_load_rd = 11'd0;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = 32'd0;
   logic        o_bus_req, o_bus_we, o_mem_stall, o_mem_read_data_valid;
   logic        o_daddress_valid, o_mem_abort;
   logic [31:0] o_bus_addr, o_bus_wdata, o_mem_read_data, o_daddress;
   logic [3:0]  o_bus_be;
   logic [10:0] o_mem_load_rd;

   a25_mem_load dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_exec_valid(exec_valid), .i_exec_write(exec_write),
      .i_exec_size(exec_size), .i_exec_signed(exec_signed),
      .i_exec_addr(exec_addr), .i_exec_wdata(exec_wdata),
      .i_exec_load_rd(exec_load_rd),
      .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
      .o_bus_be(o_bus_be), .o_bus_wdata(o_bus_wdata),
      .i_bus_ack(bus_ack), .i_bus_rdata(bus_rdata),
      .o_mem_stall(o_mem_stall), .o_mem_read_data(o_mem_read_data),
      .o_mem_read_data_valid(o_mem_read_data_valid),
      .o_mem_load_rd(o_mem_load_rd), .o_daddress(o_daddress),
      .o_daddress_valid(o_daddress_valid), .o_mem_abort(o_mem_abort)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [10:0] tag;
      logic [3:0]  be;
      logic [31:0] bwdata;
      logic [31:0] data;
      int          dly;
   } vec_t;

   typedef struct {
      logic        ld;
      logic [31:0] data;
      logic [10:0] tag;
      logic [31:0] daddr;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   vec_t vt[$];
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h at %0t", nm, act, req, $time);
      end
   endtask

   function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input logic [10:0] tag,
                               input logic [3:0] be, input logic [31:0] bwdata,
                               input logic [31:0] data, input int dly);
      vec_t v;
      v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
      v.rdata = rdata; v.tag = tag; v.be = be; v.bwdata = bwdata; v.data = data;
      v.dly = dly;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      exec_write   = v.wr;
      exec_size    = v.size;
      exec_signed  = v.sgn;
      exec_addr    = v.addr;
      exec_wdata   = v.wdata;
      exec_load_rd = v.tag;
   endtask

   function automatic exp_t to_exp(input vec_t v);
      exp_t e;
      e.ld = ~v.wr; e.data = v.data; e.tag = v.tag; e.daddr = v.addr;
      return e;
   endfunction

   // One complete access: accept, bus phase with v.dly wait cycles, completion.
   task automatic access(input vec_t v);
      @(posedge clk); #1;
      drive(v);
      exec_valid = 1'b1;
      @(posedge clk); #1;
      exec_valid = 1'b0;
      sb.push_back(to_exp(v));
      chk("req_after_accept", {31'd0, o_bus_req}, 32'd1);
      chk("stall_after_accept", {31'd0, o_mem_stall}, 32'd1);
      chk("bus_we", {31'd0, o_bus_we}, {31'd0, v.wr});
      chk("bus_addr", o_bus_addr, v.addr & 32'hFFFF_FFFC);
      if (v.wr) begin
         chk("bus_be", {28'd0, o_bus_be}, {28'd0, v.be});
         chk("bus_wdata", o_bus_wdata, v.bwdata);
      end
      for (int i = 0; i < v.dly; i++) begin
         @(posedge clk); #1;
         chk("req_hold", {31'd0, o_bus_req}, 32'd1);
      end
      bus_ack   = 1'b1;
      bus_rdata = v.rdata;
      @(posedge clk); #1;
      bus_ack   = 1'b0;
      bus_rdata = 32'h5A5A_5A5A;
      chk("req_after_ack", {31'd0, o_bus_req}, 32'd0);
      chk("stall_after_ack", {31'd0, o_mem_stall}, 32'd0);
      chk("rd_valid_pulse", {31'd0, o_mem_read_data_valid}, {31'd0, ~v.wr});
      chk("da_valid_pulse", {31'd0, o_daddress_valid}, 32'd1);
      @(posedge clk); #1;
      chk("rd_valid_drop", {31'd0, o_mem_read_data_valid}, 32'd0);
      chk("da_valid_drop", {31'd0, o_daddress_valid}, 32'd0);
      chk("daddr_held", o_daddress, v.addr);
   endtask

   // Completion monitor: every pulse must match the oldest expected access.
   always @(negedge clk) begin
      if (rst_n && (o_mem_read_data_valid || o_daddress_valid)) begin
         chk("pulse_not_stalled", {31'd0, o_mem_stall}, 32'd0);
         chk("daddr_valid_with_data", {31'd0, o_daddress_valid}, 32'd1);
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_pulse: got rd_valid=%b da_valid=%b, required none at %0t",
                     o_mem_read_data_valid, o_daddress_valid, $time);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_daddress", o_daddress, mon_e.daddr);
            chk("sb_is_load", {31'd0, o_mem_read_data_valid}, {31'd0, mon_e.ld});
            if (mon_e.ld) begin
               chk("sb_read_data", o_mem_read_data, mon_e.data);
               chk("sb_load_rd", {21'd0, o_mem_load_rd}, {21'd0, mon_e.tag});
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no end of test, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v1, v2;
      int   stall_cnt;

      //          wr    size      sgn   addr          wdata         rdata         tag     be       bwdata        data          dly
      vt.push_back(mk(1'b0, MEM_WORD, 1'b0, 32'h0000_1000, 32'h0,        32'hDEAD_BEEF, 11'h2A5, 4'b0000, 32'h0,        32'hDEAD_BEEF, 0));
      vt.push_back(mk(1'b0, MEM_BYTE, 1'b1, 32'h0000_1003, 32'h0,        32'h8011_2233, 11'h011, 4'b0000, 32'h0,        32'hFFFF_FF80, 1));
      vt.push_back(mk(1'b0, MEM_BYTE, 1'b0, 32'h0000_1003, 32'h0,        32'h8011_2233, 11'h012, 4'b0000, 32'h0,        32'h0000_0080, 0));
      vt.push_back(mk(1'b1, MEM_HALF, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'h0,        11'h013, 4'b1100, 32'hABCD_ABCD, 32'h0,        2));
      vt.push_back(mk(1'b0, MEM_HALF, 1'b1, 32'h0000_2002, 32'h0,        32'h8001_7FFF, 11'h014, 4'b0000, 32'h0,        32'hFFFF_8001, 0));
      vt.push_back(mk(1'b0, MEM_HALF, 1'b1, 32'h0000_2000, 32'h0,        32'h8001_7FFF, 11'h015, 4'b0000, 32'h0,        32'h0000_7FFF, 3));
      vt.push_back(mk(1'b1, MEM_BYTE, 1'b0, 32'h0000_1001, 32'h1234_56A5, 32'h0,        11'h016, 4'b0010, 32'hA5A5_A5A5, 32'h0,        0));
      vt.push_back(mk(1'b1, MEM_WORD, 1'b0, 32'h0000_4000, 32'hCAFE_F00D, 32'h0,        11'h017, 4'b1111, 32'hCAFE_F00D, 32'h0,        1));
      vt.push_back(mk(1'b0, MEM_BYTE, 1'b0, 32'h0000_1002, 32'h0,        32'h11C5_2233, 11'h7FF, 4'b0000, 32'h0,        32'h0000_00C5, 0));
      vt.push_back(mk(1'b0, 2'b11,    1'b1, 32'h0000_5000, 32'h0,        32'h89AB_CDEF, 11'h400, 4'b0000, 32'h0,        32'h89AB_CDEF, 0));
      vt.push_back(mk(1'b0, MEM_HALF, 1'b0, 32'h0000_6002, 32'h0,        32'hF00D_1234, 11'h001, 4'b0000, 32'h0,        32'h0000_F00D, 1));
      vt.push_back(mk(1'b1, MEM_BYTE, 1'b0, 32'h0000_1003, 32'h0000_0077, 32'h0,        11'h002, 4'b1000, 32'h7777_7777, 32'h0,        0));
`ifndef A25_MEM_ALIGN_CHECK_EN
      // misaligned low bits ignored when the alignment check is not built
      vt.push_back(mk(1'b0, MEM_HALF, 1'b0, 32'h0000_7003, 32'h0,        32'hBEEF_1234, 11'h003, 4'b0000, 32'h0,        32'h0000_BEEF, 0));
      vt.push_back(mk(1'b0, MEM_WORD, 1'b0, 32'h0000_7001, 32'h0,        32'h0123_4567, 11'h004, 4'b0000, 32'h0,        32'h0123_4567, 0));
      vt.push_back(mk(1'b1, MEM_HALF, 1'b0, 32'h0000_7001, 32'h0000_9876, 32'h0,        11'h005, 4'b0011, 32'h9876_9876, 32'h0,        0));
`endif

      // reset state
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_bus_req", {31'd0, o_bus_req}, 32'd0);
      chk("rst_bus_we", {31'd0, o_bus_we}, 32'd0);
      chk("rst_bus_addr", o_bus_addr, 32'd0);
      chk("rst_bus_be", {28'd0, o_bus_be}, 32'd0);
      chk("rst_bus_wdata", o_bus_wdata, 32'd0);
      chk("rst_stall", {31'd0, o_mem_stall}, 32'd0);
      chk("rst_read_data", o_mem_read_data, 32'd0);
      chk("rst_rd_valid", {31'd0, o_mem_read_data_valid}, 32'd0);
      chk("rst_load_rd", {21'd0, o_mem_load_rd}, 32'd0);
      chk("rst_daddress", o_daddress, 32'd0);
      chk("rst_da_valid", {31'd0, o_daddress_valid}, 32'd0);
      chk("rst_abort", {31'd0, o_mem_abort}, 32'd0);

      foreach (vt[i]) access(vt[i]);

      // ack while idle must be ignored
      @(posedge clk); #1;
      bus_ack = 1'b1;
      bus_rdata = 32'h1111_1111;
      @(posedge clk); #1;
      bus_ack = 1'b0;
      @(posedge clk); #1;
      chk("idle_ack_da_valid", {31'd0, o_daddress_valid}, 32'd0);
      chk("idle_ack_stall", {31'd0, o_mem_stall}, 32'd0);

      // long ack with execute request held: second accepted on the pulse cycle
      v1 = mk(1'b0, MEM_WORD, 1'b0, 32'h0000_8000, 32'h0, 32'h0BAD_F00D, 11'h155, 4'b0, 32'h0, 32'h0BAD_F00D, 0);
      v2 = mk(1'b0, MEM_BYTE, 1'b1, 32'h0000_9001, 32'h0, 32'h0000_FF00, 11'h0AA, 4'b0, 32'h0, 32'hFFFF_FFFF, 0);
      @(posedge clk); #1;
      drive(v1);
      exec_valid = 1'b1;
      @(posedge clk); #1;
      sb.push_back(to_exp(v1));
      drive(v2);
      stall_cnt = 0;
      for (int c = 0; c < 6; c++) begin
         if (c == 5) begin
            bus_ack = 1'b1;
            bus_rdata = v1.rdata;
         end
         if (c == 4) chk("held_addr_while_stalled", o_bus_addr, 32'h0000_8000);
         @(negedge clk);
         if (o_mem_stall) stall_cnt++;
         @(posedge clk); #1;
      end
      bus_ack = 1'b0;
      chk("stall_cycles", stall_cnt, 32'd6);
      chk("b2b_stall_low", {31'd0, o_mem_stall}, 32'd0);
      chk("b2b_first_valid", {31'd0, o_mem_read_data_valid}, 32'd1);
      sb.push_back(to_exp(v2));
      @(posedge clk); #1;
      exec_valid = 1'b0;
      chk("b2b_second_req", {31'd0, o_bus_req}, 32'd1);
      chk("b2b_second_addr", o_bus_addr, 32'h0000_9000);
      bus_ack = 1'b1;
      bus_rdata = v2.rdata;
      @(posedge clk); #1;
      bus_ack = 1'b0;
      chk("b2b_second_valid", {31'd0, o_mem_read_data_valid}, 32'd1);
      @(posedge clk); #1;

      // reset while busy, ack arriving afterwards is discarded
      drive(mk(1'b0, MEM_WORD, 1'b0, 32'h0000_A000, 32'h0, 32'h0, 11'h321, 4'b0, 32'h0, 32'h0, 0));
      exec_valid = 1'b1;
      @(posedge clk); #1;
      exec_valid = 1'b0;
      chk("rb_req_busy", {31'd0, o_bus_req}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("rb_req_dropped", {31'd0, o_bus_req}, 32'd0);
      chk("rb_stall", {31'd0, o_mem_stall}, 32'd0);
      bus_ack = 1'b1;
      bus_rdata = 32'h7777_7777;
      @(posedge clk); #1;
      bus_ack = 1'b0;
      chk("rb_rd_valid", {31'd0, o_mem_read_data_valid}, 32'd0);
      chk("rb_da_valid", {31'd0, o_daddress_valid}, 32'd0);
      chk("rb_read_data", o_mem_read_data, 32'd0);
      chk("rb_load_rd", {21'd0, o_mem_load_rd}, 32'd0);
      chk("rb_daddress", o_daddress, 32'd0);
      chk("rb_bus_addr", o_bus_addr, 32'd0);

`ifdef A25_MEM_ALIGN_CHECK_EN
      // misaligned word load is aborted without any bus activity
      @(posedge clk); #1;
      drive(mk(1'b0, MEM_WORD, 1'b0, 32'h0000_3001, 32'h0, 32'h0, 11'h066, 4'b0, 32'h0, 32'h0, 0));
      exec_valid = 1'b1;
      @(posedge clk); #1;
      exec_valid = 1'b0;
      chk("ab_abort_pulse", {31'd0, o_mem_abort}, 32'd1);
      chk("ab_stall", {31'd0, o_mem_stall}, 32'd1);
      chk("ab_no_req", {31'd0, o_bus_req}, 32'd0);
      @(posedge clk); #1;
      chk("ab_abort_end", {31'd0, o_mem_abort}, 32'd0);
      chk("ab_stall_end", {31'd0, o_mem_stall}, 32'd0);
      chk("ab_no_req2", {31'd0, o_bus_req}, 32'd0);
      @(posedge clk); #1;
      chk("ab_no_valid", {31'd0, o_daddress_valid}, 32'd0);
      access(mk(1'b0, MEM_HALF, 1'b0, 32'h0000_3002, 32'h0, 32'h4321_8765, 11'h067, 4'b0, 32'h0, 32'h0000_4321, 0));
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
